change_dispenser: RTL and testbench

- Output end of the vending machine's change path. Accepts a change amount from vending_machine over a valid/ready handshake.
- Splits the amount into denominations 10/5/2/1, largest first, and emits one coin-release pulse per cycle to the coin-hopper drivers.
- Tracks a per-denomination coin inventory and reports any shortfall when the inventory cannot cover the amount.

---
 rtl/change_dispenser_if.sv | 47 ++++
 rtl/change_dispenser.sv | 179 +++++++++++++++++
 tb/tb_change_dispenser.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Bundles every non-clock/reset signal of the change dispenser.
//   master : vending-machine side (drives enable, change_valid, change, refill)
//   slave  : dispenser side (drives ready, coin outputs, status and inventory)
//
// Handshake: a change amount transfers on the rising clk edge where
// change_valid && change_ready are both high. change is sampled only on that
// edge; holding change_valid while change_ready is low has no effect. The
// source may keep change_valid asserted across busy periods and it will be
// taken on the first edge where change_ready is high.
//
// state_dbg exposes the dispenser FSM state for checkers.
// -----------------------------------------------------------------------------
interface change_dispenser_if #(
  parameter int AMT_W = 5,
  parameter int INV_W = 5
);
  logic             enable;
  logic             change_valid;
  logic [AMT_W-1:0] change;
  logic             change_ready;
  logic             refill;
  logic             coin_valid;
  logic [3:0]       coin_sel;
  logic             done;
  logic             short_err;
  logic [AMT_W-1:0] short_amt;
  logic [INV_W-1:0] inv10;
  logic [INV_W-1:0] inv5;
  logic [INV_W-1:0] inv2;
  logic [INV_W-1:0] inv1;
  logic [7:0]       paid_total;
  logic [1:0]       state_dbg;

  modport master (
    output enable, change_valid, change, refill,
    input  change_ready, coin_valid, coin_sel, done, short_err, short_amt,
    input  inv10, inv5, inv2, inv1, paid_total, state_dbg
  );

  modport slave (
    input  enable, change_valid, change, refill,
    output change_ready, coin_valid, coin_sel, done, short_err, short_amt,
    output inv10, inv5, inv2, inv1, paid_total, state_dbg
  );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Output end of the vending machine's change path. Takes a change amount over
// a valid/ready handshake, pays it out greedily in coins of 10/5/2/1 (one coin
// per cycle), tracks per-denomination inventory and reports any unpaid
// remainder at the end of the transaction.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : change_dispenser_if.slave
//            enable        in   low pauses dispensing
//            change_valid  in   change amount offered
//            change        in   amount to pay out
//            change_ready  out  amount can be accepted
//            refill        in   reload inventories (IDLE only)
//            coin_valid    out  one coin released this cycle
//            coin_sel      out  one-hot {c10,c5,c2,c1}, 0 when no coin
//            done          out  one-cycle end-of-transaction pulse
//            short_err     out  with done: amount not fully paid
//            short_amt     out  with done: unpaid remainder
//            inv10..inv1   out  current inventory counts
//            paid_total    out  running value dispensed, mod 256
//            state_dbg     out  FSM state
// AMT_W must be at least 4 so the amount can hold the value 10.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int AMT_W    = 5,
  parameter int INV_W    = 5,
  parameter int INIT_C10 = 10,
  parameter int INIT_C5  = 10,
  parameter int INIT_C2  = 10,
  parameter int INIT_C1  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  change_dispenser_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [INV_W-1:0] LOAD10 = INV_W'(INIT_C10);
  localparam logic [INV_W-1:0] LOAD5  = INV_W'(INIT_C5);
  localparam logic [INV_W-1:0] LOAD2  = INV_W'(INIT_C2);
  localparam logic [INV_W-1:0] LOAD1  = INV_W'(INIT_C1);

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic             change_ready_q;
  logic             coin_valid_q;
  logic [3:0]       coin_sel_q;
  logic             done_q;
  logic             short_err_q;
  logic [AMT_W-1:0] short_amt_q;
  logic [INV_W-1:0] inv10_q, inv5_q, inv2_q, inv1_q;
  logic [7:0]       paid_q;

  // Greedy pick: largest denomination that fits the remainder and is in
  // stock. A zero-count denomination is never picked, so counters cannot
  // underflow. pick_sel == 0 means nothing can be paid this cycle.
  logic [3:0]       pick_sel;
  logic [AMT_W-1:0] pick_amt;
  logic [7:0]       pick_val;

  always_comb begin
    pick_sel = 4'b0000;
    pick_amt = '0;
    pick_val = 8'd0;
    if (rem >= AMT_W'(10) && inv10_q != '0) begin
      pick_sel = 4'b1000;
      pick_amt = AMT_W'(10);
      pick_val = 8'd10;
    end else if (rem >= AMT_W'(5) && inv5_q != '0) begin
      pick_sel = 4'b0100;
      pick_amt = AMT_W'(5);
      pick_val = 8'd5;
    end else if (rem >= AMT_W'(2) && inv2_q != '0) begin
      pick_sel = 4'b0010;
      pick_amt = AMT_W'(2);
      pick_val = 8'd2;
    end else if (rem >= AMT_W'(1) && inv1_q != '0) begin
      pick_sel = 4'b0001;
      pick_amt = AMT_W'(1);
      pick_val = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem            <= '0;
      change_ready_q <= bus.enable;
      coin_valid_q   <= 1'b0;
      coin_sel_q     <= 4'b0000;
      done_q         <= 1'b0;
      short_err_q    <= 1'b0;
      short_amt_q    <= '0;
      inv10_q        <= LOAD10;
      inv5_q         <= LOAD5;
      inv2_q         <= LOAD2;
      inv1_q         <= LOAD1;
      paid_q         <= 8'd0;
    end else begin
      // Pulse-type outputs default low every cycle.
      coin_valid_q <= 1'b0;
      coin_sel_q   <= 4'b0000;
      done_q       <= 1'b0;

      case (state)
        IDLE: begin
          change_ready_q <= bus.enable;
          // Refill and accept may coincide; the reload lands on this edge, so
          // the first dispense cycle already sees the refilled counts.
          if (bus.refill) begin
            inv10_q <= LOAD10;
            inv5_q  <= LOAD5;
            inv2_q  <= LOAD2;
            inv1_q  <= LOAD1;
          end
          if (bus.change_valid && change_ready_q) begin
            rem            <= bus.change;
            change_ready_q <= 1'b0;
            state          <= DISPENSE;
          end
        end

        DISPENSE: begin
          change_ready_q <= 1'b0;
          if (bus.enable) begin
            if (pick_sel != 4'b0000) begin
              coin_valid_q <= 1'b1;
              coin_sel_q   <= pick_sel;
              rem          <= rem - pick_amt;
              paid_q       <= paid_q + pick_val;
              if (pick_sel[3]) inv10_q <= inv10_q - INV_W'(1);
              if (pick_sel[2]) inv5_q  <= inv5_q  - INV_W'(1);
              if (pick_sel[1]) inv2_q  <= inv2_q  - INV_W'(1);
              if (pick_sel[0]) inv1_q  <= inv1_q  - INV_W'(1);
            end else begin
              // Either fully paid or stuck; no backtracking is attempted.
              done_q      <= 1'b1;
              short_err_q <= (rem != '0);
              short_amt_q <= rem;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          change_ready_q <= bus.enable;
          state          <= IDLE;
        end

        default: begin
          change_ready_q <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign bus.change_ready = change_ready_q;
  assign bus.coin_valid   = coin_valid_q;
  assign bus.coin_sel     = coin_sel_q;
  assign bus.done         = done_q;
  assign bus.short_err    = short_err_q;
  assign bus.short_amt    = short_amt_q;
  assign bus.inv10        = inv10_q;
  assign bus.inv5         = inv5_q;
  assign bus.inv2         = inv2_q;
  assign bus.inv1         = inv1_q;
  assign bus.paid_total   = paid_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Three dispensers with different starting inventories, each driven through
// its own interface instance. A transaction-level model computes the greedy
// coin list, remainder, inventory and paid total for every accepted amount.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int AMT_W = 5;
  localparam int INV_W = 5;
  localparam int N     = 3;

  // Starting counts per instance; j: 0=c10, 1=c5, 2=c2, 3=c1.
  function automatic int init_cnt(int k, int j);
    case (k)
      1:       return (j == 0) ? 1 : ((j == 3) ? 2 : 0);
      2:       return (j == 3) ? 0 : 10;
      default: return 10;
    endcase
  endfunction

  function automatic int denom(int j);
    case (j)
      0:       return 10;
      1:       return 5;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- per-instance signals ----------------
  logic             en   [N];
  logic             cv   [N];
  logic             rf   [N];
  logic [AMT_W-1:0] chg  [N];
  logic             rdy  [N];
  logic             cvld [N];
  logic [3:0]       sel  [N];
  logic             dn   [N];
  logic             serr [N];
  logic [AMT_W-1:0] samt [N];
  logic [INV_W-1:0] inv  [N][4];
  logic [7:0]       paid [N];

  for (genvar g = 0; g < N; g++) begin : gi
    change_dispenser_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus ();
    assign bus.enable       = en[g];
    assign bus.change_valid = cv[g];
    assign bus.change       = chg[g];
    assign bus.refill       = rf[g];
    assign rdy[g]    = bus.change_ready;
    assign cvld[g]   = bus.coin_valid;
    assign sel[g]    = bus.coin_sel;
    assign dn[g]     = bus.done;
    assign serr[g]   = bus.short_err;
    assign samt[g]   = bus.short_amt;
    assign inv[g][0] = bus.inv10;
    assign inv[g][1] = bus.inv5;
    assign inv[g][2] = bus.inv2;
    assign inv[g][3] = bus.inv1;
    assign paid[g]   = bus.paid_total;

    change_dispenser #(
      .AMT_W(AMT_W), .INV_W(INV_W),
      .INIT_C10(init_cnt(g, 0)), .INIT_C5(init_cnt(g, 1)),
      .INIT_C2(init_cnt(g, 2)),  .INIT_C1(init_cnt(g, 3))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  // ---------------- scoreboard / model ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  int         exp_short;
  int         m_inv  [N][4];
  int         m_paid [N];

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reload(int k);
    for (int j = 0; j < 4; j++) m_inv[k][j] = init_cnt(k, j);
  endtask

  // Greedy payout: repeatedly take the largest in-stock coin not exceeding
  // what is still owed; stop when nothing fits.
  task automatic model_plan(int k, int amt);
    int rem;
    int pick;
    exp_q.delete();
    rem = amt;
    forever begin
      pick = -1;
      for (int j = 0; j < 4; j++)
        if (pick < 0 && denom(j) <= rem && m_inv[k][j] > 0) pick = j;
      if (pick < 0) break;
      m_inv[k][pick]--;
      rem       -= denom(pick);
      m_paid[k]  = (m_paid[k] + denom(pick)) % 256;
      exp_q.push_back(4'(8 >> pick));
    end
    exp_short = rem;
  endtask

  task automatic check_store(int k);
    check($sformatf("i%0d inv10", k), inv[k][0], m_inv[k][0]);
    check($sformatf("i%0d inv5", k),  inv[k][1], m_inv[k][1]);
    check($sformatf("i%0d inv2", k),  inv[k][2], m_inv[k][2]);
    check($sformatf("i%0d inv1", k),  inv[k][3], m_inv[k][3]);
    check($sformatf("i%0d paid_total", k), paid[k], m_paid[k]);
  endtask

  // ---------------- driver tasks ----------------
  // Called with time sitting at a falling edge (or at time 0).
  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b1; cv[k] = 1'b0; rf[k] = 1'b0; chg[k] = '0;
      model_reload(k);
      m_paid[k] = 0;
    end
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("i%0d rst change_ready", k), rdy[k], 1);
      check($sformatf("i%0d rst coin_valid", k), cvld[k], 0);
      check($sformatf("i%0d rst coin_sel", k), sel[k], 0);
      check($sformatf("i%0d rst done", k), dn[k], 0);
      check($sformatf("i%0d rst short_err", k), serr[k], 0);
      check($sformatf("i%0d rst short_amt", k), samt[k], 0);
      check_store(k);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("i%0d post-rst done", k), dn[k], 0);
      check($sformatf("i%0d post-rst coin_valid", k), cvld[k], 0);
      check($sformatf("i%0d post-rst change_ready", k), rdy[k], 1);
    end
  endtask

  // One transaction on instance k. pause_at/pause_len drop enable for
  // pause_len cycles once pause_at coins are out; rnd adds random enable
  // drops and refill pulses while busy; abort_at resets after that many coins.
  task automatic run_txn(int k, int amt, bit refill_acc, bit hold,
                         int pause_at, int pause_len, bit rnd, int abort_at);
    int       coins;
    int       paused_left;
    bit       pause_started;
    bit       finished;
    logic [3:0] e;
    coins = 0; paused_left = 0; pause_started = 0; finished = 0;

    check($sformatf("i%0d ready before accept", k), rdy[k], 1);
    cv[k]  = 1'b1;
    chg[k] = AMT_W'(amt);
    rf[k]  = refill_acc;
    en[k]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (refill_acc) model_reload(k);
    model_plan(k, amt);
    check($sformatf("i%0d ready after accept", k), rdy[k], 0);
    check($sformatf("i%0d no coin at T", k), cvld[k], 0);
    rf[k] = 1'b0;
    if (!hold) begin
      cv[k]  = 1'b0;
      chg[k] = AMT_W'($urandom_range(0, 31));
    end

    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (coins == abort_at) begin
        do_reset(1);
        return;
      end
      if (!pause_started && coins == pause_at) begin
        paused_left   = pause_len;
        pause_started = 1;
      end
      if (paused_left > 0) begin
        en[k] = 1'b0;
        paused_left--;
      end else if (rnd && $urandom_range(0, 5) == 0) en[k] = 1'b0;
      else en[k] = 1'b1;
      if (rnd) rf[k] = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("i%0d ready busy", k), rdy[k], 0);
      if (!en[k]) begin
        check($sformatf("i%0d paused coin_valid", k), cvld[k], 0);
        check($sformatf("i%0d paused done", k), dn[k], 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("i%0d coin_valid", k), cvld[k], 1);
        check($sformatf("i%0d coin_sel", k), sel[k], e);
        check($sformatf("i%0d early done", k), dn[k], 0);
        coins++;
      end else begin
        check($sformatf("i%0d done", k), dn[k], 1);
        check($sformatf("i%0d done coin_valid", k), cvld[k], 0);
        check($sformatf("i%0d done coin_sel", k), sel[k], 0);
        check($sformatf("i%0d short_err", k), serr[k], (exp_short != 0) ? 1 : 0);
        check($sformatf("i%0d short_amt", k), samt[k], exp_short);
        finished = 1;
      end
    end
    if (!finished) check($sformatf("i%0d txn cycle budget", k), 0, 1);

    en[k] = 1'b1;
    rf[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("i%0d done is one pulse", k), dn[k], 0);
    check($sformatf("i%0d ready after done", k), rdy[k], 1);
    check_store(k);
  endtask

  task automatic idle_refill(int k);
    rf[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rf[k] = 1'b0;
    model_reload(k);
    check_store(k);
  endtask

  task automatic idle_enable(int k);
    en[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("i%0d ready with enable low", k), rdy[k], 0);
    en[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("i%0d ready with enable back", k), rdy[k], 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset(3);

    // Defaults: 18 -> 10,5,2,1, no shortfall.
    run_txn(0, 18, 0, 0, -1, 0, 0, -1);
    // Zero amount: done straight away, inventory untouched.
    run_txn(0, 0, 0, 0, -1, 0, 0, -1);

    // Fresh inventory, 31 with enable dropped for 3 cycles after coin 2.
    do_reset(1);
    run_txn(0, 31, 0, 0, 2, 3, 0, -1);
    idle_refill(0);

    // change_valid held high with 25 across the busy period: taken twice,
    // each time only when change_ready is back.
    run_txn(0, 25, 0, 1, -1, 0, 0, -1);
    run_txn(0, 25, 0, 0, -1, 0, 0, -1);

    // Reset after two coins of a 25 payout.
    run_txn(0, 25, 0, 0, -1, 0, 0, 2);

    // Sparse inventory {1,0,0,2}: 14 -> 10,1,1 with 2 short.
    run_txn(1, 14, 0, 0, -1, 0, 0, -1);
    // No 1-coins: 6 -> 5 then stuck with 1 short.
    run_txn(2, 6, 0, 0, -1, 0, 0, -1);

    idle_enable(0);

    // Random traffic with random pauses and ignored refills while busy.
    repeat (60) begin
      int k;
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 7) == 0) idle_refill(k);
      run_txn(k, $urandom_range(0, 31), ($urandom_range(0, 3) == 0), 0,
              -1, 0, 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
